// File: rtl/interconn_priority_pkg.sv
// interconn_priority_pkg: default sizing shared by the crossbar and its per-receiver arbiters
package interconn_priority_pkg;
  localparam int N_MVU = 8;
  localparam int W_WORD = 64;
  localparam int BADDR_W = 15;
endpackage

// File: rtl/interconn_priority_arb.sv
// interconn_priority_arb: one receiver's lowest-index-wins arbiter, data mux and output register
module interconn_priority_arb import interconn_priority_pkg::*; #(
  parameter int N = N_MVU,
  parameter int W = W_WORD,
  parameter int BADDR = BADDR_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     req,
  input  logic [BADDR-1:0] send_addr [N-1:0],
  input  logic [W-1:0]     send_word [N-1:0],
  output logic [N-1:0]     recv_from,
  output logic             recv_en,
  output logic [BADDR-1:0] recv_addr,
  output logic [W-1:0]     recv_word
);
  logic [N-1:0] gnt;
  logic [BADDR-1:0] addr_d;
  logic [W-1:0] word_d;
  // isolating the lowest set bit gives the fixed-priority one-hot grant
  assign gnt = req & (~req + 1'b1);
  always_comb begin
    addr_d = '0;
    word_d = '0;
    for (int s = 0; s < N; s++) begin
      addr_d |= send_addr[s] & {BADDR{gnt[s]}};
      word_d |= send_word[s] & {W{gnt[s]}};
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      recv_from <= '0;
      recv_en <= 1'b0;
      recv_addr <= '0;
      recv_word <= '0;
    end else begin
      recv_from <= gnt;
      recv_en <= |req;
      recv_addr <= addr_d;
      recv_word <= word_d;
    end
  end
endmodule

// File: rtl/interconn_priority.sv
// interconn_priority: registered N x N MVU write crossbar with fixed-priority arbitration per receiver
module interconn_priority import interconn_priority_pkg::*; #(
  parameter int N = N_MVU,
  parameter int W = W_WORD,
  parameter int BADDR = BADDR_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N-1:0]     send_to   [N-1:0],
  input  logic             send_en   [N-1:0],
  input  logic [BADDR-1:0] send_addr [N-1:0],
  input  logic [W-1:0]     send_word [N-1:0],
  output logic [N-1:0]     recv_from [N-1:0],
  output logic             recv_en   [N-1:0],
  output logic [BADDR-1:0] recv_addr [N-1:0],
  output logic [W-1:0]     recv_word [N-1:0]
);
  logic [N-1:0] req [N-1:0];
  always_comb begin
    for (int d = 0; d < N; d++)
      for (int s = 0; s < N; s++)
        req[d][s] = send_en[s] & send_to[s][d];
  end
  for (genvar d = 0; d < N; d++) begin : g_rx
    interconn_priority_arb #(.N(N), .W(W), .BADDR(BADDR)) u_arb (
      .clk(clk),
      .clr(clr),
      .req(req[d]),
      .send_addr(send_addr),
      .send_word(send_word),
      .recv_from(recv_from[d]),
      .recv_en(recv_en[d]),
      .recv_addr(recv_addr[d]),
      .recv_word(recv_word[d])
    );
  end
endmodule

// File: tb/tb_interconn_priority.sv
// tb_interconn_priority: directed checks of unicast, multicast, contention, parallel and reset
module tb_interconn_priority;
  localparam int N = 8;
  localparam int W = 64;
  localparam int BADDR = 15;
  localparam logic [W-1:0] W_ODD = 64'hDEADBEEFDEADBEEF;
  localparam logic [W-1:0] W_EVEN = 64'hBEEFDEADBEEFDEAD;
  logic clk = 1'b0;
  logic clr;
  logic [N-1:0] send_to [N-1:0];
  logic send_en [N-1:0];
  logic [BADDR-1:0] send_addr [N-1:0];
  logic [W-1:0] send_word [N-1:0];
  logic [N-1:0] recv_from [N-1:0];
  logic recv_en [N-1:0];
  logic [BADDR-1:0] recv_addr [N-1:0];
  logic [W-1:0] recv_word [N-1:0];
  int total = 0;
  int bad = 0;
  logic [N-1:0] e_from [N-1:0];
  logic e_en [N-1:0];
  logic [BADDR-1:0] e_addr [N-1:0];
  logic [W-1:0] e_word [N-1:0];

  interconn_priority dut (
    .clk(clk), .clr(clr),
    .send_to(send_to), .send_en(send_en), .send_addr(send_addr), .send_word(send_word),
    .recv_from(recv_from), .recv_en(recv_en), .recv_addr(recv_addr), .recv_word(recv_word)
  );

  always #5 clk = ~clk;

  task automatic idle();
    for (int s = 0; s < N; s++) begin
      send_en[s] = 1'b0;
      send_to[s] = '0;
      send_addr[s] = '0;
      send_word[s] = '0;
    end
  endtask

  task automatic exp_clear();
    for (int d = 0; d < N; d++) begin
      e_en[d] = 1'b0;
      e_from[d] = '0;
      e_addr[d] = '0;
      e_word[d] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    for (int s = 0; s < N; s++) begin
      send_en[s] = 1'b1;
      send_to[s] = '1;
      send_addr[s] = BADDR'(s + 7);
      send_word[s] = W_ODD;
    end
    step();
    for (int d = 0; d < N; d++) begin
      total += 4;
      if (recv_en[d] !== 1'b0) begin bad++; $display("FAIL reset_en[%0d] got=%b want=0", d, recv_en[d]); end
      if (recv_from[d] !== '0) begin bad++; $display("FAIL reset_from[%0d] got=%h want=00", d, recv_from[d]); end
      if (recv_addr[d] !== '0) begin bad++; $display("FAIL reset_addr[%0d] got=%h want=0", d, recv_addr[d]); end
      if (recv_word[d] !== '0) begin bad++; $display("FAIL reset_word[%0d] got=%h want=0", d, recv_word[d]); end
    end
    clr = 1'b0;
    idle();
    step();
    for (int d = 0; d < N; d++) begin
      total += 2;
      if (recv_en[d] !== 1'b0) begin bad++; $display("FAIL post_reset_en[%0d] got=%b want=0", d, recv_en[d]); end
      if (recv_from[d] !== '0) begin bad++; $display("FAIL post_reset_from[%0d] got=%h want=00", d, recv_from[d]); end
    end
  endtask

  task automatic test_unicast();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        idle();
        exp_clear();
        send_en[i] = 1'b1;
        send_to[i] = N'(1) << j;
        send_addr[i] = BADDR'(i + j + 1);
        send_word[i] = i[0] ? W_ODD : W_EVEN;
        e_en[j] = 1'b1;
        e_from[j] = N'(1) << i;
        e_addr[j] = BADDR'(i + j + 1);
        e_word[j] = i[0] ? W_ODD : W_EVEN;
        step();
        for (int d = 0; d < N; d++) begin
          total += 4;
          if (recv_en[d] !== e_en[d]) begin bad++; $display("FAIL uni_en s=%0d d=%0d rx=%0d got=%b want=%b", i, j, d, recv_en[d], e_en[d]); end
          if (recv_from[d] !== e_from[d]) begin bad++; $display("FAIL uni_from s=%0d d=%0d rx=%0d got=%h want=%h", i, j, d, recv_from[d], e_from[d]); end
          if (recv_addr[d] !== e_addr[d]) begin bad++; $display("FAIL uni_addr s=%0d d=%0d rx=%0d got=%h want=%h", i, j, d, recv_addr[d], e_addr[d]); end
          if (recv_word[d] !== e_word[d]) begin bad++; $display("FAIL uni_word s=%0d d=%0d rx=%0d got=%h want=%h", i, j, d, recv_word[d], e_word[d]); end
        end
      end
  endtask

  task automatic test_multicast(input int fan);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        idle();
        exp_clear();
        send_en[i] = 1'b1;
        send_addr[i] = BADDR'(100 + 8 * i + j);
        send_word[i] = {32'(i), 32'(j)};
        for (int k = 0; k < fan; k++) begin
          send_to[i][(j + k) % N] = 1'b1;
          e_en[(j + k) % N] = 1'b1;
          e_from[(j + k) % N] = N'(1) << i;
          e_addr[(j + k) % N] = BADDR'(100 + 8 * i + j);
          e_word[(j + k) % N] = {32'(i), 32'(j)};
        end
        step();
        for (int d = 0; d < N; d++) begin
          total += 4;
          if (recv_en[d] !== e_en[d]) begin bad++; $display("FAIL mc%0d_en s=%0d j=%0d rx=%0d got=%b want=%b", fan, i, j, d, recv_en[d], e_en[d]); end
          if (recv_from[d] !== e_from[d]) begin bad++; $display("FAIL mc%0d_from s=%0d j=%0d rx=%0d got=%h want=%h", fan, i, j, d, recv_from[d], e_from[d]); end
          if (recv_addr[d] !== e_addr[d]) begin bad++; $display("FAIL mc%0d_addr s=%0d j=%0d rx=%0d got=%h want=%h", fan, i, j, d, recv_addr[d], e_addr[d]); end
          if (recv_word[d] !== e_word[d]) begin bad++; $display("FAIL mc%0d_word s=%0d j=%0d rx=%0d got=%h want=%h", fan, i, j, d, recv_word[d], e_word[d]); end
        end
        if (fan == 3) begin
          send_en[i] = 1'b0;
          step();
          for (int d = 0; d < N; d++) begin
            total += 2;
            if (recv_en[d] !== 1'b0) begin bad++; $display("FAIL mc3_drop_en s=%0d rx=%0d got=%b want=0", i, d, recv_en[d]); end
            if (recv_from[d] !== '0) begin bad++; $display("FAIL mc3_drop_from s=%0d rx=%0d got=%h want=00", i, d, recv_from[d]); end
          end
        end
      end
  endtask

  task automatic test_contention();
    idle();
    send_en[2] = 1'b1; send_to[2] = 8'h08; send_addr[2] = 15'h0222; send_word[2] = 64'h2222_0000_2222_0000;
    send_en[5] = 1'b1; send_to[5] = 8'h08; send_addr[5] = 15'h0555; send_word[5] = 64'h5555_0000_5555_0000;
    step();
    total += 5;
    if (recv_en[3] !== 1'b1) begin bad++; $display("FAIL cont_en got=%b want=1", recv_en[3]); end
    if (recv_from[3] !== 8'h04) begin bad++; $display("FAIL cont_from got=%h want=04", recv_from[3]); end
    if (recv_addr[3] !== 15'h0222) begin bad++; $display("FAIL cont_addr got=%h want=0222", recv_addr[3]); end
    if (recv_word[3] !== 64'h2222_0000_2222_0000) begin bad++; $display("FAIL cont_word got=%h want=2222000022220000", recv_word[3]); end
    if (recv_en[5] !== 1'b0) begin bad++; $display("FAIL cont_other_en got=%b want=0", recv_en[5]); end
    idle();
    send_en[5] = 1'b1; send_to[5] = 8'h08; send_addr[5] = 15'h0555; send_word[5] = 64'h5555_0000_5555_0000;
    send_en[6] = 1'b1; send_to[6] = 8'h00; send_addr[6] = 15'h0666; send_word[6] = '1;
    step();
    total += 3;
    if (recv_from[3] !== 8'h20) begin bad++; $display("FAIL cont_solo_from got=%h want=20", recv_from[3]); end
    if (recv_addr[3] !== 15'h0555) begin bad++; $display("FAIL cont_solo_addr got=%h want=0555", recv_addr[3]); end
    if (recv_en[6] !== 1'b0) begin bad++; $display("FAIL empty_mask_en got=%b want=0", recv_en[6]); end
  endtask

  task automatic test_parallel();
    idle();
    send_en[0] = 1'b1; send_to[0] = 8'h02; send_addr[0] = 15'h0010; send_word[0] = 64'hA0;
    send_en[1] = 1'b1; send_to[1] = 8'h01; send_addr[1] = 15'h0020; send_word[1] = 64'hB1;
    step();
    total += 6;
    if (recv_from[1] !== 8'h01) begin bad++; $display("FAIL par_from1 got=%h want=01", recv_from[1]); end
    if (recv_addr[1] !== 15'h0010) begin bad++; $display("FAIL par_addr1 got=%h want=0010", recv_addr[1]); end
    if (recv_word[1] !== 64'hA0) begin bad++; $display("FAIL par_word1 got=%h want=a0", recv_word[1]); end
    if (recv_from[0] !== 8'h02) begin bad++; $display("FAIL par_from0 got=%h want=02", recv_from[0]); end
    if (recv_addr[0] !== 15'h0020) begin bad++; $display("FAIL par_addr0 got=%h want=0020", recv_addr[0]); end
    if (recv_word[0] !== 64'hB1) begin bad++; $display("FAIL par_word0 got=%h want=b1", recv_word[0]); end
  endtask

  initial begin
    clr = 1'b1;
    idle();
    step();
    test_reset();
    test_unicast();
    test_multicast(2);
    test_multicast(3);
    test_contention();
    test_parallel();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
